// File: rtl/spi_flash_stream.sv
// SPI flash streaming reader: sends READ_CMD plus a 24-bit address, then shifts
// words in continuously and presents them on a valid/ready output.
module spi_flash_stream #(
   parameter int         WORD_BITS = 16,
   parameter logic [7:0] READ_CMD  = 8'h03
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [23:0]          addr,
   output logic                 spi_cs_n,
   output logic                 spi_clk,
   output logic                 spi_mosi,
   input  logic                 spi_miso,
   output logic [WORD_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 busy
);

   localparam int CNT_W = (WORD_BITS > 32) ? $clog2(WORD_BITS) : 5;

   typedef enum logic [1:0] {IDLE, CMD, DATA, STALL} state_t;

   state_t               state;
   logic                 phase;
   logic [CNT_W-1:0]     bit_cnt;
   logic [31:0]          cmd_sr;
   logic [WORD_BITS-1:0] shift_sr;
   logic [WORD_BITS-1:0] word_next;
   logic                 handshake;

   assign word_next = {shift_sr[WORD_BITS-2:0], spi_miso};
   assign handshake = data_valid && data_ready;
   assign busy      = (state != IDLE);

   // phase=0 is the low half of an SPI bit (mosi changes), phase=1 the high half;
   // miso is captured on the edge that closes the high half.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= 1'b0;
         bit_cnt    <= '0;
         spi_cs_n   <= 1'b1;
         spi_clk    <= 1'b0;
         spi_mosi   <= 1'b0;
         data_valid <= 1'b0;
         data_out   <= '0;
      end else if (stop && state != IDLE) begin
         state      <= IDLE;
         phase      <= 1'b0;
         bit_cnt    <= '0;
         spi_cs_n   <= 1'b1;
         spi_clk    <= 1'b0;
         spi_mosi   <= 1'b0;
         data_valid <= 1'b0;
      end else begin
         if (handshake)
            data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state    <= CMD;
                  phase    <= 1'b0;
                  bit_cnt  <= '0;
                  spi_cs_n <= 1'b0;
                  spi_clk  <= 1'b0;
                  spi_mosi <= READ_CMD[7];
                  cmd_sr   <= {READ_CMD[6:0], addr, 1'b0};
               end
            end
            CMD: begin
               if (!phase) begin
                  spi_clk <= 1'b1;
                  phase   <= 1'b1;
               end else begin
                  spi_clk <= 1'b0;
                  phase   <= 1'b0;
                  if (bit_cnt == CNT_W'(31)) begin
                     state    <= DATA;
                     bit_cnt  <= '0;
                     spi_mosi <= 1'b0;
                  end else begin
                     bit_cnt  <= bit_cnt + CNT_W'(1);
                     spi_mosi <= cmd_sr[31];
                     cmd_sr   <= {cmd_sr[30:0], 1'b0};
                  end
               end
            end
            DATA: begin
               if (!phase) begin
                  spi_clk <= 1'b1;
                  phase   <= 1'b1;
               end else begin
                  spi_clk  <= 1'b0;
                  phase    <= 1'b0;
                  shift_sr <= word_next;
                  if (bit_cnt == CNT_W'(WORD_BITS-1)) begin
                     bit_cnt <= '0;
                     // Output slot busy and not draining: park the word in shift_sr.
                     if (!data_valid || data_ready) begin
                        data_out   <= word_next;
                        data_valid <= 1'b1;
                     end else begin
                        state <= STALL;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            STALL: begin
               if (data_ready) begin
                  data_out   <= shift_sr;
                  data_valid <= 1'b1;
                  state      <= DATA;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_stream.sv
// Scoreboarded bench for spi_flash_stream with a behavioural mode-0 flash model.
module tb_spi_flash_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [23:0] addr = '0;
   logic        spi_cs_n, spi_clk, spi_mosi;
   logic        spi_miso = 1'b0;
   logic [15:0] data_out;
   logic        data_valid;
   logic        data_ready = 1'b1;
   logic        busy;

   int          tests = 0;
   int          fails = 0;
   int          cur = 0;
   logic [15:0] exp_q[$];
   logic [15:0] sb_exp;
   logic [15:0] mem[8];
   int          rises = 0;
   int          fj;
   logic [31:0] cmd_cap = '0;

   spi_flash_stream #(.WORD_BITS(16), .READ_CMD(8'h03)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .addr(addr),
      .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   // Flash: captures 32 command bits on rising spi_clk, then shifts memory out
   // on falling spi_clk; deselect restarts from word 0.
   always @(posedge spi_clk or negedge spi_clk or posedge spi_cs_n) begin
      if (spi_cs_n) begin
         rises    = 0;
         spi_miso = 1'b0;
         cmd_cap  = '0;
      end else if (spi_clk) begin
         if (rises < 32) cmd_cap = {cmd_cap[30:0], spi_mosi};
         rises++;
      end else if (rises >= 32) begin
         fj       = rises - 32;
         spi_miso = mem[(fj / 16) % 8][15 - (fj % 16)];
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (data_valid === 1'b1 && data_ready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL sb_unexpected: got %h expected no word (cycle %0d)", data_out, cur);
            end else begin
               sb_exp = exp_q.pop_front();
               if (data_out !== sb_exp) begin
                  fails++;
                  $display("FAIL sb_word: got %h expected %h (cycle %0d)", data_out, sb_exp, cur);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cur);
      end
   endtask

   task automatic goto(input int n);
      while (cur < n) begin
         @(posedge clk);
         cur++;
      end
      @(negedge clk);
   endtask

   task automatic drive_at(input int n);
      while (cur < n) begin
         @(posedge clk);
         cur++;
      end
      #1;
   endtask

   task automatic do_start(input logic [23:0] a, input int nwords);
      for (int i = 0; i < nwords; i++) exp_q.push_back(mem[i]);
      @(posedge clk);
      #1 start = 1'b1;
      addr = a;
      @(posedge clk);
      #1 start = 1'b0;
      cur = 1;
   endtask

   task automatic pulse_stop(input int n);
      drive_at(n);
      stop = 1'b1;
      @(posedge clk);
      cur++;
      #1 stop = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_cs_n"},  32'(spi_cs_n),   32'd1);
      chk({tag, "_sclk"},  32'(spi_clk),    32'd0);
      chk({tag, "_mosi"},  32'(spi_mosi),   32'd0);
      chk({tag, "_valid"}, 32'(data_valid), 32'd0);
      chk({tag, "_busy"},  32'(busy),       32'd0);
   endtask

   task automatic cmd_check(input logic [23:0] a, input int last_k);
      logic [31:0] e;
      e = {8'h03, a};
      for (int k = 0; k <= last_k; k++) begin
         goto(1 + 2 * k);
         chk("cmd_cs_n",   32'(spi_cs_n), 32'd0);
         chk("cmd_lo_clk", 32'(spi_clk),  32'd0);
         chk("cmd_mosi",   32'(spi_mosi), 32'(e[31 - k]));
         goto(2 + 2 * k);
         chk("cmd_hi_clk", 32'(spi_clk),  32'd1);
      end
      if (last_k == 31) chk("cmd_word", cmd_cap, e);
   endtask

   task automatic wait_empty();
      int g = 0;
      while (exp_q.size() != 0 && g < 400) begin
         goto(cur + 1);
         g++;
      end
      chk("sb_drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      mem = '{16'hA5C3, 16'h3C5A, 16'h0F0F, 16'hFFFF, 16'h0000, 16'h8001, 16'h1234, 16'hBEEF};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_idle("reset");
      chk("reset_dout", 32'(data_out), 32'd0);
      rst = 1'b0;

      // Streaming with consumer always ready
      do_start(24'h123456, 4);
      cmd_check(24'h123456, 31);
      goto(65);
      chk("data_lo_clk", 32'(spi_clk),  32'd0);
      chk("data_mosi",   32'(spi_mosi), 32'd0);
      goto(96);
      chk("w0_pre_valid", 32'(data_valid), 32'd0);
      goto(97);
      chk("w0_valid", 32'(data_valid), 32'd1);
      chk("w0_data",  32'(data_out),   32'h0000A5C3);
      goto(128);
      chk("w1_pre_valid", 32'(data_valid), 32'd0);
      goto(129);
      chk("w1_valid", 32'(data_valid), 32'd1);
      chk("w1_data",  32'(data_out),   32'h00003C5A);
      wait_empty();
      pulse_stop(cur + 1);
      goto(cur);
      chk_idle("stop1");

      // Back-pressure: stall at the second word, then resume
      do_start(24'h000100, 4);
      drive_at(96);
      data_ready = 1'b0;
      goto(97);
      chk("st_w0_valid", 32'(data_valid), 32'd1);
      chk("st_w0_data",  32'(data_out),   32'h0000A5C3);
      goto(128);
      chk("st_last_hi", 32'(spi_clk), 32'd1);
      goto(129);
      chk("stall_sclk", 32'(spi_clk),  32'd0);
      chk("stall_cs_n", 32'(spi_cs_n), 32'd0);
      chk("stall_busy", 32'(busy),     32'd1);
      chk("stall_hold", 32'(data_out), 32'h0000A5C3);
      goto(135);
      chk("stall_sclk2", 32'(spi_clk), 32'd0);
      drive_at(136);
      data_ready = 1'b1;
      goto(137);
      chk("resume_lo",   32'(spi_clk),    32'd0);
      chk("resume_vld",  32'(data_valid), 32'd1);
      chk("resume_data", 32'(data_out),   32'h00003C5A);
      goto(138);
      chk("resume_hi", 32'(spi_clk), 32'd1);
      goto(168);
      chk("st_w2_pre", 32'(data_valid), 32'd0);
      goto(169);
      chk("st_w2_valid", 32'(data_valid), 32'd1);
      chk("st_w2_data",  32'(data_out),   32'h00000F0F);
      wait_empty();
      pulse_stop(cur + 1);
      goto(cur);
      chk_idle("stop2");

      // Abort mid-command, then a fresh start re-sends the whole command
      do_start(24'h123456, 0);
      cmd_check(24'h123456, 24);
      pulse_stop(50);
      goto(51);
      chk_idle("midcmd");
      do_start(24'hABCDEF, 1);
      cmd_check(24'hABCDEF, 31);
      wait_empty();
      pulse_stop(cur + 1);
      goto(cur);
      chk_idle("stop3");

      // Start and stop together in IDLE
      @(posedge clk);
      #1 start = 1'b1;
      stop = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      stop = 1'b0;
      cur = 1;
      goto(1);
      chk("ss_cs_n", 32'(spi_cs_n), 32'd1);
      chk("ss_busy", 32'(busy),     32'd0);
      goto(3);
      chk("ss_cs_n2", 32'(spi_cs_n), 32'd1);

      // Reset pulsed during DATA
      do_start(24'h000000, 0);
      drive_at(96);
      data_ready = 1'b0;
      goto(97);
      chk("rd_w0_data", 32'(data_out), 32'h0000A5C3);
      drive_at(110);
      rst = 1'b1;
      @(posedge clk);
      cur++;
      #1 rst = 1'b0;
      goto(111);
      chk_idle("midrst");
      chk("midrst_dout", 32'(data_out), 32'd0);
      data_ready = 1'b1;
      goto(115);
      chk("midrst_cs_n2", 32'(spi_cs_n), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
